// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and load/store paths.
// One outstanding transaction at a time, with fetch-starvation guard and response timeout.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] StreakMax = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TcntLast  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e        r_state, w_state_nxt;
  logic          r_owner, w_owner_nxt;   // 1 = data path owns the port
  logic          r_we, w_we_nxt;         // owner's transaction is a store
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;

  logic          w_winner_d, w_sel_d, w_sel_req, w_issue, w_grant;
  logic          w_resp_ok, w_timeout, w_resp;
  logic [DW-1:0] w_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_streak <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_we     <= w_we_nxt;
      r_streak <= w_streak_nxt;
      r_tcnt   <= w_tcnt_nxt;
    end
  end

  // Data wins ties until it has taken MAX_D_STREAK grants in a row over a waiting fetch.
  assign w_winner_d = d_req && (!i_req || (r_streak != StreakMax));
  assign w_sel_d    = (r_state == StIdle) ? w_winner_d : r_owner;
  assign w_sel_req  = w_sel_d ? d_req : i_req;
  assign w_issue    = ((r_state == StIdle) || (r_state == StReq)) && w_sel_req;
  assign w_grant    = w_issue && m_gnt;
  assign w_resp_ok  = (r_state == StWait) && m_rvalid;
  assign w_timeout  = (r_state == StWait) && !m_rvalid && (r_tcnt == TcntLast);
  assign w_resp     = w_resp_ok || w_timeout;
  assign w_rdata    = (w_resp_ok && !r_we) ? m_rdata : '0;

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_we_nxt     = r_we;
    w_streak_nxt = r_streak;
    w_tcnt_nxt   = r_tcnt;
    unique case (r_state)
      StIdle: begin
        if (w_issue) begin
          w_owner_nxt = w_winner_d;
          w_we_nxt    = w_winner_d && d_we;
          w_state_nxt = m_gnt ? StWait : StReq;
        end
      end
      StReq: begin
        if (!w_sel_req) begin
          w_state_nxt = StIdle;
        end else if (m_gnt) begin
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        w_tcnt_nxt = r_tcnt + TW'(1);
        if (w_resp) begin
          w_tcnt_nxt  = '0;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_grant) begin
      if (!w_sel_d || !i_req) begin
        w_streak_nxt = '0;
      end else if (r_streak != StreakMax) begin
        w_streak_nxt = r_streak + SW'(1);
      end
    end
  end

  // Combinational outputs are gated by rst_n so they clear asynchronously too.
  assign m_req    = rst_n && w_issue;
  assign m_we     = rst_n && w_issue && w_sel_d && d_we;
  assign m_addr   = (rst_n && w_issue) ? (w_sel_d ? d_addr : i_addr) : '0;
  assign m_wdata  = (rst_n && w_issue && w_sel_d) ? d_wdata : '0;
  assign m_be     = (rst_n && w_issue && w_sel_d) ? d_be : '0;

  assign i_gnt    = rst_n && w_grant && !w_sel_d;
  assign d_gnt    = rst_n && w_grant && w_sel_d;
  assign i_rvalid = rst_n && w_resp && !r_owner;
  assign d_rvalid = rst_n && w_resp && r_owner;
  assign i_err    = rst_n && w_timeout && !r_owner;
  assign d_err    = rst_n && w_timeout && r_owner;
  assign i_rdata  = (rst_n && w_resp && !r_owner) ? w_rdata : '0;
  assign d_rdata  = (rst_n && w_resp && r_owner) ? w_rdata : '0;
  assign busy     = rst_n && (r_state != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected responses,
// an independent monitor pops and checks them whenever i_rvalid/d_rvalid fires.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we, m_gnt, m_rvalid, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: grant follows gnt_en, response one cycle after grant when resp_en.
  logic         gnt_en = 1'b1;
  logic         resp_en = 1'b1;
  logic         force_rv = 1'b0;
  logic         rv_q = 1'b0;
  logic [31:0]  rdata_q = '0;
  logic [31:0]  mem [0:255];
  logic [255:0] wr_flag = '0;

  assign m_gnt    = gnt_en;
  assign m_rvalid = rv_q | force_rv;
  assign m_rdata  = rdata_q;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'hC0DE};
  endfunction

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (rst_n && m_req && m_gnt && resp_en) begin
      rv_q <= 1'b1;
      if (m_we) begin
        mem[m_addr[9:2]]     <= m_wdata;
        wr_flag[m_addr[9:2]] <= 1'b1;
        rdata_q              <= 32'hFFFF_FFFF;
      end else begin
        rdata_q <= wr_flag[m_addr[9:2]] ? mem[m_addr[9:2]] : dflt(m_addr);
      end
    end
  end

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t expq[$];
  logic glog[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (i_gnt) glog.push_back(1'b0);
      if (d_gnt) glog.push_back(1'b1);
      if (i_rvalid || d_rvalid) begin
        if (expq.size() == 0) begin
          chk("unexpected_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
        end else begin
          e = expq.pop_front();
          chk("rv_port", {30'b0, i_rvalid, d_rvalid}, e.is_d ? 32'h1 : 32'h2);
          chk("rdata", i_rvalid ? i_rdata : d_rdata, e.rdata);
          chk("err", {31'b0, i_rvalid ? i_err : d_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.is_d = is_d;
    e.rdata = rd;
    e.err = err;
    expq.push_back(e);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    i_req  = 1'b1;
    i_addr = a;
    forever begin
      @(negedge clk);
      if (i_gnt) begin
        chk("fetch_m_addr", m_addr, a);
        chk("fetch_m_we", {31'b0, m_we}, 32'h0);
        break;
      end
      n++;
      if (n > 50) begin
        chk("fetch_gnt_wait", 32'h0, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1 i_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be);
    int n = 0;
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_be = be;
    forever begin
      @(negedge clk);
      if (d_gnt) begin
        chk("data_m_we", {31'b0, m_we}, {31'b0, we});
        chk("data_m_addr", m_addr, a);
        if (we) chk("data_m_wdata", m_wdata, wd);
        chk("data_m_be", {28'b0, m_be}, {28'b0, be});
        break;
      end
      n++;
      if (n > 50) begin
        chk("data_gnt_wait", 32'h0, 32'h1);
        break;
      end
    end
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("drain", expq.size(), 32'h0);
    @(posedge clk);
    #1;
  endtask

  logic ord [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int start;
    int n;
    // Reset: outputs must stay quiet even with a request pending.
    i_req = 1'b1;
    i_addr = 32'h44;
    #12;
    chk("rst_m_req", {31'b0, m_req}, 32'h0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    i_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch only, minimum latency.
    push_exp(1'b0, 32'h0050_0093, 1'b0);
    start = glog.size();
    do_fetch(32'h0);
    @(negedge clk);
    chk("fetch_rvalid_cycle1", {31'b0, i_rvalid}, 32'h1);
    chk("fetch_d_quiet", {29'b0, d_gnt, d_rvalid, d_err}, 32'h0);
    drain();
    chk("fetch_gnt_count", glog.size() - start, 32'h1);

    // Store then load back.
    push_exp(1'b1, 32'h0, 1'b0);
    do_data(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b1111);
    drain();
    push_exp(1'b1, 32'hDEAD_BEEF, 1'b0);
    do_data(1'b0, 32'h100, 32'h0, 4'b1111);
    drain();

    // Continuous contention: D,D,D,D,F repeating.
    for (int k = 0; k < 10; k++) begin
      if (ord[k]) push_exp(1'b1, 32'h0080_C0DE, 1'b0);
      else        push_exp(1'b0, 32'h0040_C0DE, 1'b0);
    end
    start = glog.size();
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    n = 0;
    while ((glog.size() - start) < 10 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    chk("contention_gnt_count", glog.size() - start, 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (start + k < glog.size())
        chk($sformatf("grant_order_%0d", k), {31'b0, glog[start+k]}, {31'b0, ord[k]});
    end
    drain();

    // Stalled grant: owner locked in REQ, fetch waits for data's response.
    push_exp(1'b1, 32'h0200_C0DE, 1'b0);
    push_exp(1'b0, 32'h0300_C0DE, 1'b0);
    gnt_en = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_be = 4'hF;
    @(negedge clk);
    chk("stall_c0_m_req", {31'b0, m_req}, 32'h1);
    chk("stall_c0_m_addr", m_addr, 32'h200);
    @(posedge clk);
    #1 i_req = 1'b1; i_addr = 32'h300;
    for (int c = 1; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d_m_addr", c), m_addr, 32'h200);
      chk($sformatf("stall_c%0d_gnts", c), {30'b0, i_gnt, d_gnt}, 32'h0);
      @(posedge clk);
      #1;
    end
    gnt_en = 1'b1;
    @(negedge clk);
    chk("stall_c3_gnts", {30'b0, i_gnt, d_gnt}, 32'h1);
    @(posedge clk);
    #1 d_req = 1'b0;
    @(negedge clk);
    chk("stall_c4_no_i_gnt", {31'b0, i_gnt}, 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_c5_i_gnt", {31'b0, i_gnt}, 32'h1);
    @(posedge clk);
    #1 i_req = 1'b0;
    drain();

    // Timeout on a load, then a late response must be ignored.
    resp_en = 1'b0;
    push_exp(1'b1, 32'h0, 1'b1);
    do_data(1'b0, 32'h400, 32'h0, 4'hF);
    n = 1;
    forever begin
      @(negedge clk);
      if (d_rvalid || n >= 40) break;
      n++;
    end
    chk("timeout_cycle", n, 32'd16);
    @(posedge clk);
    #1 force_rv = 1'b1;
    @(negedge clk);
    chk("late_rvalid_ignored", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    @(posedge clk);
    #1 force_rv = 1'b0;
    resp_en = 1'b1;
    drain();

    // Asynchronous reset while waiting for a response.
    resp_en = 1'b0;
    do_fetch(32'h8);
    #2;
    chk("wait_busy", {31'b0, busy}, 32'h1);
    d_req = 1'b1; d_addr = 32'h500; d_we = 1'b1; d_wdata = 32'h1234_5678;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ctrl", {23'b0, i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err, m_req, m_we, busy},
        32'h0);
    chk("arst_m_addr", m_addr, 32'h0);
    chk("arst_m_wdata", m_wdata, 32'h0);
    chk("arst_rdata", i_rdata | d_rdata, 32'h0);
    d_req = 1'b0;
    d_we = 1'b0;
    resp_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_exp(1'b0, 32'h0050_0093, 1'b0);
    do_fetch(32'h0);
    drain();

    chk("exp_queue_empty", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch path and the load/store data path.
- Used when the CPU runs against a single memory macro instead of split instruction and data memories.
- Arbitrates between the two requesters and sequences one outstanding transaction at a time over a req/gnt/rvalid handshake.
- Guards against fetch starvation and against a hung memory, using a response timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch is pending.
- TIMEOUT, 16, cycles to wait for m_rvalid after grant before an error response.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held with i_addr stable until i_gnt.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch request accepted (1-cycle pulse).
- i_rvalid  out  1  fetch response valid (1-cycle pulse).
- i_rdata  out  DW  fetch response data.
- i_err  out  1  fetch response is a timeout error; valid with i_rvalid.
- d_req  in  1  data request; held with d_* fields stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_be  in  DW/8  byte enables.
- d_gnt  out  1  data request accepted (pulse).
- d_rvalid  out  1  data response valid (pulse); issued for stores too.
- d_rdata  out  DW  load data; 0 for stores.
- d_err  out  1  data timeout error; valid with d_rvalid.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_be  out  DW/8  memory byte enables.
- m_gnt  in  1  memory accepts request this cycle.
- m_rvalid  in  1  memory response valid.
- m_rdata  in  DW  memory read data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values, applied asynchronously while rst_n=0:
  - state=IDLE, owner=FETCH, streak=0, tcnt=0.
  - All outputs 0: every gnt, rvalid, err, m_req and m_we; all m_* data/address fields; i_rdata; d_rdata.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Winner selection, combinational:
    - d_req only → DATA.
    - i_req only → FETCH.
    - Both, with streak < MAX_D_STREAK → DATA.
    - Both, with streak == MAX_D_STREAK → FETCH.
  - m_req=1 and m_* driven from the winner in the same cycle.
  - If m_gnt=1: pulse the winner's gnt, latch owner, go to WAIT.
  - Otherwise: latch owner, go to REQ.
- REQ:
  - Owner is locked; no re-arbitration even if the other requester asserts.
  - m_req=1 with the owner's fields.
  - On m_gnt: pulse the owner's gnt, go to WAIT.
- WAIT:
  - m_req=0; tcnt increments each cycle.
  - On m_rvalid: owner's rvalid=1 combinationally, rdata=m_rdata (stores drive rdata=0), err=0, tcnt←0, go to IDLE.
  - If tcnt reaches TIMEOUT-1 without m_rvalid: owner's rvalid=1, err=1, rdata=0, go to IDLE.
- Latency:
  - Minimum request-to-response is 2 cycles: gnt in cycle 0, rvalid in cycle 1.
  - Re-arbitration happens on the cycle after the response; there is no same-cycle reissue.
- Streak counter (updated on each data grant):
  - d_req and i_req both high at the data grant → streak++, saturating at MAX_D_STREAK.
  - i_req low at the data grant → streak←0.
  - Any fetch grant → streak←0.
- Stale responses: m_rvalid in IDLE or REQ is ignored and produces no rvalid. This covers late responses after a timeout.
- Requests withdrawn before grant (protocol violation): from REQ, return to IDLE with m_req=0 in the next cycle.
- Reset mid-transaction aborts immediately; no response is issued for the outstanding request.
- Only the owner's gnt/rvalid/err may assert; the other requester's outputs stay 0.

Test Plan:
- Fetch only, m_gnt tied 1, m_rvalid 1 cycle later with m_rdata=0x00500093 → i_gnt in cycle 0, i_rvalid in cycle 1, i_rdata=0x00500093, i_err=0, d_* quiet.
- Store, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b1111 → m_we=1, m_addr=0x100, m_wdata=0xDEADBEEF, d_gnt pulse, d_rvalid with d_rdata=0.
- i_req and d_req held high continuously, memory 1-cycle → grant order D,D,D,D,F,D,D,D,D,F.
- m_gnt held 0 for 3 cycles while d_req wins, then i_req asserted → m_addr stays d_addr in REQ; d_gnt on the 4th cycle; no i_gnt until d's response completes.
- Granted load, m_rvalid never arrives, TIMEOUT=16 → d_rvalid=1, d_err=1, d_rdata=0 on the 16th cycle after grant; a later m_rvalid produces no rvalid.
- rst_n dropped in WAIT → busy=0 and all outputs 0 immediately (asynchronous); after release, a new fetch completes normally.
